uart_axil_mux: RTL

AXI4-Lite register front-end serving `NCH` independent UART channels, each with its own TX and RX byte buffer. It is the multi-channel successor of the single-channel UART controller. It adds:
- a decoded per-channel register map;
- order-independent AW/W capture with backpressure;
- sticky write-1-to-clear error flags;
- per-channel maskable interrupts.

It sits between the system AXI4-Lite interconnect and the per-channel TX/RX buffers.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_chan_regs.sv | 56 +++++
 rtl/uart_axil_mux.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-channel UART AXI4-Lite register front-end.
package uart_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } resp_e;

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;
    localparam logic [1:0] RegFlags  = 2'd3;

    localparam int unsigned FlagRxAvail = 0;
    localparam int unsigned FlagTxOvf   = 1;
    localparam int unsigned FlagRxOvf   = 2;
    localparam int unsigned FlagRxUdf   = 3;

    typedef enum logic [2:0] {
        WrIdle,
        WrHaveAw,
        WrHaveW,
        WrExec,
        WrTxWait,
        WrResp
    } wr_state_e;

    typedef enum logic {
        RdIdle,
        RdValid
    } rd_state_e;

endpackage

// File: rtl/uart_chan_regs.sv
// Per-channel CTRL / FLAGS registers and the registered interrupt line.
module uart_chan_regs
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_ctrl_we,
    input  logic       i_flags_we,
    input  logic [3:0] i_wdata,
    input  logic       i_rx_avail,
    input  logic       i_tx_overflow,
    input  logic       i_rx_overflow,
    input  logic       i_rx_underflow,
    output logic [3:0] o_ctrl,
    output logic [3:0] o_flags,
    output logic       o_irq
);

    logic [3:0] ctrl_q, ctrl_d;
    logic [3:0] sticky_q, sticky_d;
    logic       irq_q, irq_d;
    logic [3:0] set_vec;
    logic [3:0] clr_vec;

    always_comb begin
        set_vec              = '0;
        set_vec[FlagTxOvf]   = i_tx_overflow;
        set_vec[FlagRxOvf]   = i_rx_overflow;
        set_vec[FlagRxUdf]   = i_rx_underflow;
        clr_vec              = i_flags_we ? i_wdata : 4'b0000;

        ctrl_d = i_ctrl_we ? i_wdata : ctrl_q;
        // Set is applied after the clear so a same-cycle event survives W1C.
        sticky_d = ((sticky_q & ~clr_vec) | set_vec) & 4'b1110;

        o_flags              = sticky_q;
        o_flags[FlagRxAvail] = i_rx_avail;
        irq_d                = |(o_flags & ctrl_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctrl_q   <= '0;
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            sticky_q <= sticky_d;
            irq_q    <= irq_d;
        end
    end

    assign o_ctrl = ctrl_q;
    assign o_irq  = irq_q;

endmodule

// File: rtl/uart_axil_mux.sv
// AXI4-Lite front-end for NCH UART channels: address decode, write/read FSMs, TX/RX stream muxing.
module uart_axil_mux
    import uart_pkg::*;
#(
    parameter int unsigned         NCH       = 4,
    parameter int unsigned         AXI_ALEN  = 32,
    parameter int unsigned         AXI_DLEN  = 32,
    parameter int unsigned         UART_DLEN = 8,
    parameter logic [AXI_ALEN-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_axi_awvalid,
    input  logic [AXI_ALEN-1:0]      i_axi_awaddr,
    output logic                     o_axi_awready,
    input  logic                     i_axi_wvalid,
    input  logic [AXI_DLEN-1:0]      i_axi_wdata,
    input  logic [3:0]               i_axi_wstrb,
    output logic                     o_axi_wready,
    output logic                     o_axi_bvalid,
    output logic [1:0]               o_axi_bresp,
    input  logic                     i_axi_bready,
    input  logic                     i_axi_arvalid,
    input  logic [AXI_ALEN-1:0]      i_axi_araddr,
    output logic                     o_axi_arready,
    output logic                     o_axi_rvalid,
    output logic [AXI_DLEN-1:0]      o_axi_rdata,
    output logic [1:0]               o_axi_rresp,
    input  logic                     i_axi_rready,
    output logic [NCH-1:0]           o_txb_tvalid,
    input  logic [NCH-1:0]           i_txb_tready,
    output logic [NCH*UART_DLEN-1:0] o_txb_tdata,
    input  logic [NCH-1:0]           i_txb_overflow,
    input  logic [NCH-1:0]           i_rxb_tvalid,
    output logic [NCH-1:0]           o_rxb_tready,
    input  logic [NCH*UART_DLEN-1:0] i_rxb_tdata,
    input  logic [NCH-1:0]           i_rxb_overflow,
    input  logic [NCH-1:0]           i_rxb_underflow,
    output logic [NCH-1:0]           o_irq
);

    localparam logic [AXI_ALEN-1:0] Span = AXI_ALEN'(NCH * 16);

    function automatic logic dec_bad(input logic [AXI_ALEN-1:0] off);
        return (off >= Span) || (off[1:0] != 2'b00);
    endfunction

    wr_state_e wstate_q, wstate_d;
    rd_state_e rstate_q, rstate_d;
    logic [AXI_ALEN-1:0]  awaddr_q, awaddr_d;
    logic [UART_DLEN-1:0] wdata_q, wdata_d;
    logic                 wstrb0_q, wstrb0_d;
    resp_e                bresp_q, bresp_d;
    resp_e                rresp_q, rresp_d;
    logic [AXI_DLEN-1:0]  rdata_q, rdata_d;
    logic [UART_DLEN-1:0] txdata_q, txdata_d;
    logic [NCH-1:0]       pop_q, pop_d;
    // Holds all ready outputs low until the cycle after reset is released.
    logic                 rdy_en_q;

    logic [AXI_ALEN-1:0]  woff, roff;
    logic [1:0]           wreg, rreg;
    logic                 w_bad, r_bad;
    logic [NCH-1:0]       wsel, rsel;
    logic                 aw_hs, w_hs, ar_hs;
    logic                 tx_rdy_w;
    logic [NCH-1:0]       ctrl_we, flags_we;
    logic [3:0]           ch_ctrl  [NCH];
    logic [3:0]           ch_flags [NCH];
    logic                 r_rxv, r_txr;
    logic [UART_DLEN-1:0] r_rxd;
    logic [3:0]           r_ctrl, r_flags;

    assign woff  = awaddr_q - BASE_ADDR;
    assign roff  = i_axi_araddr - BASE_ADDR;
    assign wreg  = woff[3:2];
    assign rreg  = roff[3:2];
    assign w_bad = dec_bad(woff);
    assign r_bad = dec_bad(roff);

    assign o_axi_awready = rdy_en_q && (wstate_q == WrIdle || wstate_q == WrHaveW);
    assign o_axi_wready  = rdy_en_q && (wstate_q == WrIdle || wstate_q == WrHaveAw);
    assign o_axi_arready = rdy_en_q && (rstate_q == RdIdle);
    assign o_axi_bvalid  = (wstate_q == WrResp);
    assign o_axi_rvalid  = (rstate_q == RdValid);
    assign o_axi_bresp   = bresp_q;
    assign o_axi_rresp   = rresp_q;
    assign o_axi_rdata   = rdata_q;
    assign o_rxb_tready  = pop_q;

    assign aw_hs = i_axi_awvalid && o_axi_awready;
    assign w_hs  = i_axi_wvalid && o_axi_wready;
    assign ar_hs = i_axi_arvalid && o_axi_arready;

    // Channel selects and per-channel read/stream muxes.
    always_comb begin
        wsel    = '0;
        rsel    = '0;
        r_rxv   = 1'b0;
        r_txr   = 1'b0;
        r_rxd   = '0;
        r_ctrl  = '0;
        r_flags = '0;
        o_txb_tdata = '0;
        for (int c = 0; c < NCH; c++) begin
            wsel[c] = (woff[7:4] == 4'(c));
            rsel[c] = (roff[7:4] == 4'(c));
            o_txb_tdata[c*UART_DLEN +: UART_DLEN] = txdata_q;
            if (rsel[c]) begin
                r_rxv   = i_rxb_tvalid[c];
                r_txr   = i_txb_tready[c];
                r_rxd   = i_rxb_tdata[c*UART_DLEN +: UART_DLEN];
                r_ctrl  = ch_ctrl[c];
                r_flags = ch_flags[c];
            end
        end
        tx_rdy_w     = |(wsel & i_txb_tready);
        o_txb_tvalid = wsel & {NCH{wstate_q == WrTxWait}};
    end

    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb0_d = wstrb0_q;
        bresp_d  = bresp_q;
        txdata_d = txdata_q;
        ctrl_we  = '0;
        flags_we = '0;
        if (aw_hs) awaddr_d = i_axi_awaddr;
        if (w_hs) begin
            wdata_d  = i_axi_wdata[UART_DLEN-1:0];
            wstrb0_d = i_axi_wstrb[0];
        end
        unique case (wstate_q)
            WrIdle: begin
                if (aw_hs && w_hs) wstate_d = WrExec;
                else if (aw_hs)    wstate_d = WrHaveAw;
                else if (w_hs)     wstate_d = WrHaveW;
            end
            WrHaveAw: if (w_hs)  wstate_d = WrExec;
            WrHaveW:  if (aw_hs) wstate_d = WrExec;
            WrExec: begin
                wstate_d = WrResp;
                bresp_d  = RespOkay;
                if (w_bad) begin
                    bresp_d = RespDecerr;
                end else begin
                    unique case (wreg)
                        RegData: begin
                            if (wstrb0_q) begin
                                txdata_d = wdata_q;
                                wstate_d = WrTxWait;
                            end else begin
                                bresp_d = RespSlverr;
                            end
                        end
                        RegStatus: bresp_d  = RespSlverr;
                        RegCtrl:   ctrl_we  = wsel & {NCH{wstrb0_q}};
                        RegFlags:  flags_we = wsel & {NCH{wstrb0_q}};
                        default: ;
                    endcase
                end
            end
            WrTxWait: if (tx_rdy_w)     wstate_d = WrResp;
            WrResp:   if (i_axi_bready) wstate_d = WrIdle;
            default:  wstate_d = WrIdle;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        pop_d    = '0;
        unique case (rstate_q)
            RdIdle: begin
                if (ar_hs) begin
                    rstate_d = RdValid;
                    rresp_d  = RespOkay;
                    rdata_d  = '0;
                    if (r_bad) begin
                        rresp_d = RespDecerr;
                    end else begin
                        unique case (rreg)
                            RegData: begin
                                if (r_rxv) begin
                                    rdata_d = AXI_DLEN'(r_rxd);
                                    pop_d   = rsel;
                                end else begin
                                    rresp_d = RespSlverr;
                                end
                            end
                            RegStatus: rdata_d = AXI_DLEN'({r_rxv, r_txr});
                            RegCtrl:   rdata_d = AXI_DLEN'(r_ctrl);
                            RegFlags:  rdata_d = AXI_DLEN'(r_flags);
                            default: ;
                        endcase
                    end
                end
            end
            RdValid: if (i_axi_rready) rstate_d = RdIdle;
            default: rstate_d = RdIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wstate_q <= WrIdle;
            rstate_q <= RdIdle;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb0_q <= 1'b0;
            bresp_q  <= RespOkay;
            rresp_q  <= RespOkay;
            rdata_q  <= '0;
            txdata_q <= '0;
            pop_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb0_q <= wstrb0_d;
            bresp_q  <= bresp_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            txdata_q <= txdata_d;
            pop_q    <= pop_d;
            rdy_en_q <= 1'b1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        uart_chan_regs u_regs (
            .clk            (clk),
            .rstn           (rstn),
            .i_ctrl_we      (ctrl_we[c]),
            .i_flags_we     (flags_we[c]),
            .i_wdata        (wdata_q[3:0]),
            .i_rx_avail     (i_rxb_tvalid[c]),
            .i_tx_overflow  (i_txb_overflow[c]),
            .i_rx_overflow  (i_rxb_overflow[c]),
            .i_rx_underflow (i_rxb_underflow[c]),
            .o_ctrl         (ch_ctrl[c]),
            .o_flags        (ch_flags[c]),
            .o_irq          (o_irq[c])
        );
    end

    logic unused_ok;
    assign unused_ok = ^{i_axi_wdata[AXI_DLEN-1:UART_DLEN], i_axi_wstrb[3:1]};

endmodule
